pulse_meter: RTL and testbench

- Measuring-side counterpart of the team's countdown timer: the timer turns a loaded cycle count into a busy pulse; this block turns a busy-style pulse back into a cycle count.
- Samples a single-bit level input, counts the consecutive cycles it is high, and presents the length on a valid/ready output port.
- Used to check timer durations in-system and to measure externally generated gate pulses. Loading the timer with N must read back as exactly N.

---
 rtl/pulse_meter.sv | 126 ++++++++++++
 tb/tb_pulse_meter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_meter.sv
// ----------------------------------------------------------------------------
// pulse_meter: measures consecutive high cycles of level_in, valid/ready result
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pulse_meter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             level_in,
  output logic [WIDTH-1:0] result,
  output logic             result_sat,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             missed
);

  localparam logic [WIDTH-1:0] C_MAX_COUNT = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] C_ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             sat_q, sat_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             result_sat_q, result_sat_d;
  logic             valid_q, valid_d;
  logic             missed_q, missed_d;
  logic             prev_level_q;
  logic             w_rise;

  // prev_level resets high so a pulse already present at reset release is ignored
  assign w_rise = level_in && !prev_level_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      sat_q        <= 1'b0;
      result_q     <= '0;
      result_sat_q <= 1'b0;
      valid_q      <= 1'b0;
      missed_q     <= 1'b0;
      prev_level_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      sat_q        <= sat_d;
      result_q     <= result_d;
      result_sat_q <= result_sat_d;
      valid_q      <= valid_d;
      missed_q     <= missed_d;
      prev_level_q <= level_in;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    sat_d        = sat_q;
    result_d     = result_q;
    result_sat_d = result_sat_q;
    valid_d      = valid_q;
    missed_d     = missed_q;

    case (state_q)
      S_IDLE: begin
        if (w_rise) begin
          count_d = C_ONE;
          sat_d   = 1'b0;
          state_d = S_MEASURE;
        end
      end

      S_MEASURE: begin
        if (level_in) begin
          if (count_q == C_MAX_COUNT) begin
            sat_d = 1'b1;
          end else begin
            count_d = count_q + C_ONE;
          end
        end else begin
          result_d     = count_q;
          result_sat_d = sat_q;
          valid_d      = 1'b1;
          state_d      = S_HOLD;
        end
      end

      S_HOLD: begin
        if (valid_q && result_ready) begin
          valid_d = 1'b0;
          if (w_rise) begin
            count_d = C_ONE;
            sat_d   = 1'b0;
            state_d = S_MEASURE;
          end else begin
            state_d = S_IDLE;
          end
        end else if (w_rise) begin
          // Pulse is dropped; no edge will be seen again for it.
          missed_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign result       = result_q;
  assign result_sat   = result_sat_q;
  assign result_valid = valid_q;
  assign missed       = missed_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_meter.sv
// ----------------------------------------------------------------------------
// tb_pulse_meter: directed self-checking bench for pulse_meter (WIDTH 16 and 4)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pulse_meter;

  logic        clk;
  logic        reset;
  logic        level_in;
  logic        result_ready;
  logic [15:0] result;
  logic        result_sat;
  logic        result_valid;
  logic        missed;
  logic [3:0]  result4;
  logic        result_sat4;
  logic        result_valid4;
  logic        missed4;

  int errors;
  int checks;

  pulse_meter #(.WIDTH(16)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .level_in     (level_in),
    .result       (result),
    .result_sat   (result_sat),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .missed       (missed)
  );

  pulse_meter #(.WIDTH(4)) u_dut4 (
    .clk          (clk),
    .reset        (reset),
    .level_in     (level_in),
    .result       (result4),
    .result_sat   (result_sat4),
    .result_valid (result_valid4),
    .result_ready (result_ready),
    .missed       (missed4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic high_for(input int n);
    level_in = 1'b1;
    for (int i = 0; i < n; i++) tick();
    level_in = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    level_in = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    level_in     = 1'b0;
    result_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({result_valid, result_sat, missed} !== 3'b000 || result !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: valid/sat/missed=%b result=%0d required 000 and 0",
               {result_valid, result_sat, missed}, result);
    end
    tick();
    result_ready = 1'b1;
    level_in     = 1'b1;
    tick();
    level_in = 1'b0;
    checks++;
    if (result_valid !== 1'b0) begin
      errors++;
      $display("FAIL len1_early_valid: got %b required 0", result_valid);
    end
    tick();
    checks++;
    if (result_valid !== 1'b1 || result !== 16'd1 || result_sat !== 1'b0) begin
      errors++;
      $display("FAIL len1_result: valid=%b result=%0d sat=%b required 1,1,0",
               result_valid, result, result_sat);
    end
    tick();
    checks++;
    if (result_valid !== 1'b0 || result !== 16'd1) begin
      errors++;
      $display("FAIL len1_after_xfer: valid=%b result=%0d required 0,1", result_valid, result);
    end
  endtask

  task automatic test_timer_five();
    high_for(5);
    tick();
    checks++;
    if (result_valid !== 1'b1 || result !== 16'd5 || result_sat !== 1'b0 || missed !== 1'b0) begin
      errors++;
      $display("FAIL timer5: valid=%b result=%0d sat=%b missed=%b required 1,5,0,0",
               result_valid, result, result_sat, missed);
    end
    tick();
  endtask

  task automatic test_saturation();
    high_for(20);
    tick();
    checks++;
    if (result_valid4 !== 1'b1 || result4 !== 4'd15 || result_sat4 !== 1'b1) begin
      errors++;
      $display("FAIL sat_w4: valid=%b result=%0d sat=%b required 1,15,1",
               result_valid4, result4, result_sat4);
    end
    checks++;
    if (result !== 16'd20 || result_sat !== 1'b0) begin
      errors++;
      $display("FAIL sat_w16_len20: result=%0d sat=%b required 20,0", result, result_sat);
    end
    tick();
    high_for(3);
    tick();
    checks++;
    if (result_valid4 !== 1'b1 || result4 !== 4'd3 || result_sat4 !== 1'b0) begin
      errors++;
      $display("FAIL sat_w4_next: valid=%b result=%0d sat=%b required 1,3,0",
               result_valid4, result4, result_sat4);
    end
    tick();
    high_for(15);
    tick();
    checks++;
    if (result4 !== 4'd15 || result_sat4 !== 1'b0) begin
      errors++;
      $display("FAIL sat_w4_exact15: result=%0d sat=%b required 15,0", result4, result_sat4);
    end
    tick();
  endtask

  task automatic test_missed();
    result_ready = 1'b0;
    high_for(4);
    tick();
    tick();
    level_in = 1'b1;
    tick();
    checks++;
    if (missed !== 1'b1) begin
      errors++;
      $display("FAIL missed_set: got %b required 1", missed);
    end
    tick();
    level_in = 1'b0;
    tick();
    checks++;
    if (result_valid !== 1'b1 || result !== 16'd4) begin
      errors++;
      $display("FAIL missed_hold: valid=%b result=%0d required 1,4", result_valid, result);
    end
    result_ready = 1'b1;
    tick();
    checks++;
    if (result_valid !== 1'b0) begin
      errors++;
      $display("FAIL missed_xfer: valid=%b required 0", result_valid);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (result_valid !== 1'b0 || result !== 16'd4 || missed !== 1'b1) begin
      errors++;
      $display("FAIL missed_idle: valid=%b result=%0d missed=%b required 0,4,1",
               result_valid, result, missed);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    result_ready = 1'b0;
    high_for(3);
    tick();
    checks++;
    if (result_valid !== 1'b1 || result !== 16'd3) begin
      errors++;
      $display("FAIL b2b_first: valid=%b result=%0d required 1,3", result_valid, result);
    end
    level_in     = 1'b1;
    result_ready = 1'b1;
    tick();
    checks++;
    if (result_valid !== 1'b0 || missed !== 1'b0) begin
      errors++;
      $display("FAIL b2b_xfer: valid=%b missed=%b required 0,0", result_valid, missed);
    end
    high_for(5);
    tick();
    checks++;
    if (result_valid !== 1'b1 || result !== 16'd6 || missed !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: valid=%b result=%0d missed=%b required 1,6,0",
               result_valid, result, missed);
    end
    tick();
  endtask

  task automatic test_reset_cases();
    logic seen_valid;
    result_ready = 1'b0;
    high_for(2);
    tick();
    level_in = 1'b1;
    tick();
    result_ready = 1'b1;
    tick();
    level_in = 1'b0;
    tick();
    level_in = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (missed !== 1'b1 || result !== 16'd2 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset: missed=%b result=%0d valid=%b required 1,2,0",
               missed, result, result_valid);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (missed !== 1'b0 || result !== 16'd0 || result_valid !== 1'b0 || result_sat !== 1'b0) begin
      errors++;
      $display("FAIL mid_measure_reset: missed=%b result=%0d valid=%b sat=%b required 0,0,0,0",
               missed, result, result_valid, result_sat);
    end
    reset    = 1'b0;
    level_in = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen_valid |= result_valid;
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_emit: valid seen=%b required 0", seen_valid);
    end
    level_in = 1'b1;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen_valid |= result_valid;
    end
    level_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen_valid |= result_valid;
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      errors++;
      $display("FAIL high_at_reset: valid seen=%b required 0", seen_valid);
    end
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    reset        = 1'b1;
    level_in     = 1'b0;
    result_ready = 1'b0;
    test_reset();
    test_timer_five();
    test_saturation();
    test_missed();
    test_back_to_back();
    test_reset_cases();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
